// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 encodings, divider FSM states and
// the two bit patterns used by the RISC-V divide special cases.
package rv32m_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Issue/complete bus between the execute stage (master) and the divider (slave).
// Handshake: an issue is taken when start=1 and funct3[2]=1 while the divider
// is idle; busy covers the compute cycles and done is a one-cycle pulse with out valid.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] value1;
  logic [XLEN-1:0] value2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] out;

  modport master (
    output start, funct3, value1, value2,
    input  busy, done, out
  );

  modport slave (
    input  start, funct3, value1, value2,
    output busy, done, out
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for div/divu/rem/remu: one quotient bit per
// cycle, with divide-by-zero and signed overflow resolved at issue.
module div_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus,
  output div_state_t  dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, out_q;
  logic            neg_quo_q, neg_rem_q, is_rem_q;

  logic            accept, is_signed, sign1, sign2;
  logic            div_zero, overflow, special, last_step;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] rem_n, quo_n, final_val;

  // Issue decode and operand conditioning.
  always_comb begin
    accept    = (state_q == IDLE) && bus.start && bus.funct3[2];
    is_signed = ~bus.funct3[0];
    sign1     = is_signed & bus.value1[XLEN-1];
    sign2     = is_signed & bus.value2[XLEN-1];
    mag1      = sign1 ? (~bus.value1 + 1'b1) : bus.value1;
    mag2      = sign2 ? (~bus.value2 + 1'b1) : bus.value2;
    div_zero  = (bus.value2 == '0);
    overflow  = is_signed && (bus.value1 == MIN_NEG) && (bus.value2 == ONES);
    special   = div_zero | overflow;
    last_step = (cnt_q == CW'(XLEN-1));
  end

  // Restoring step; the partial remainder stays below the divisor, so only
  // the trial difference needs the extra sign bit.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[XLEN]) begin
      rem_n = trial[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = shifted[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
    if (is_rem_q) final_val = neg_rem_q ? (~rem_n + 1'b1) : rem_n;
    else          final_val = neg_quo_q ? (~quo_n + 1'b1) : quo_n;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q == CALC);
    bus.done  = (state_q == DONE);
    bus.out   = out_q;
    dbg_state = state_q;
  end

  // out_q is written on the edge into DONE so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      out_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_rem_q <= bus.funct3[1];
            if (div_zero) begin
              out_q <= bus.funct3[1] ? bus.value1 : ONES;
            end else if (overflow) begin
              out_q <= bus.funct3[1] ? '0 : MIN_NEG;
            end else begin
              cnt_q     <= '0;
              rem_q     <= '0;
              quo_q     <= mag1;
              dvs_q     <= mag2;
              neg_quo_q <= sign1 ^ sign2;
              neg_rem_q <= sign1;
            end
          end
        end
        CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) out_q <= final_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed RV32M results, latency,
// busy duration, ignored starts and reset abort.
module tb_div_unit;
  import rv32m_pkg::*;

  logic       clk;
  logic       rst;
  div_state_t dbg_state;
  int         checks;
  int         failures;
  logic [31:0] exp_q[$];

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it to done; the unit is expected idle on entry.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit pulses);
    int          lat;
    int          busy_cnt;
    bit          seen;
    logic [31:0] got;
    logic [31:0] want;
    lat = 0; busy_cnt = 0; seen = 1'b0; got = '0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.value1 = a;
    bus.value2 = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.value1 = $urandom;
    bus.value2 = $urandom;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1'b1;
        lat  = k;
        got  = bus.out;
      end else begin
        if (pulses) begin
          bus.funct3 = F3_DIVU;
          bus.start  = (k == 5 || k == 10);
        end
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_out"}, got, want);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), (exp_lat == 33) ? 32'd32 : 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_single"}, 32'(bus.done), 32'd0);
    check({tag, "_out_hold"}, bus.out, want);
  endtask

  initial begin
    int done_cnt;
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.funct3 = 3'b000; bus.value1 = '0; bus.value2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_out", bus.out, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk); rst = 1'b0;

    // Directed vectors
    run_op("divu_100_7",  F3_DIVU, 32'd100,        32'd7,          32'd14,         33, 1'b0);
    run_op("remu_100_7",  F3_REMU, 32'd100,        32'd7,          32'd2,          33, 1'b0);
    run_op("div_m7_2",    F3_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 1'b0);
    run_op("rem_m7_2",    F3_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 1'b0);
    run_op("div_7_m2",    F3_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, 1'b0);
    run_op("rem_7_m2",    F3_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, 1'b0);
    run_op("div_m20_m6",  F3_DIV,  32'hFFFF_FFEC,  32'hFFFF_FFFA,  32'd3,          33, 1'b0);
    run_op("rem_m20_m6",  F3_REM,  32'hFFFF_FFEC,  32'hFFFF_FFFA,  32'hFFFF_FFFE,  33, 1'b0);
    run_op("div_5_0",     F3_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1'b0);
    run_op("remu_5_0",    F3_REMU, 32'd5,          32'd0,          32'd5,          1,  1'b0);
    run_op("div_ovf",     F3_DIV,  INT_MIN,        ALL_ONES,       INT_MIN,        1,  1'b0);
    run_op("rem_ovf",     F3_REM,  INT_MIN,        ALL_ONES,       32'd0,          1,  1'b0);
    run_op("divu_min_1s", F3_DIVU, INT_MIN,        ALL_ONES,       32'd0,          33, 1'b0);
    run_op("remu_1s_16",  F3_REMU, ALL_ONES,       32'd16,         32'd15,         33, 1'b0);
    run_op("divu_pulses", F3_DIVU, ALL_ONES,       32'd1,          ALL_ONES,       33, 1'b1);

    // start with funct3[2]=0 is not an issue
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.value1 = 32'd10; bus.value2 = 32'd2;
    repeat (2) begin
      @(posedge clk); #1;
      check("nonm_busy", 32'(bus.busy), 32'd0);
      check("nonm_done", 32'(bus.done), 32'd0);
    end
    bus.start = 1'b0;

    // rst and start together: reset wins
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.funct3 = F3_DIVU;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    check("rst_start_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    check("rst_start_done", 32'(bus.done), 32'd0);

    // Leave a nonzero result, then reset in the middle of the next op
    run_op("divu_pre", F3_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.value1 = 32'd1000; bus.value2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_out", bus.out, 32'd0);
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_out_kept", bus.out, 32'd0);
    run_op("divu_9_3", F3_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
